// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types for the instruction-fetch line buffer.
package lc3b_types;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned LINE_W   = 128;
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned TAG_W    = WORD_W - OFFSET_W;
    localparam int unsigned SEL_W    = 3;

    typedef logic [WORD_W-1:0] lc3b_word;
    typedef logic [LINE_W-1:0] lc3b_line;
    typedef logic [TAG_W-1:0]  lc3b_tag;

    // Line tag of a byte address.
    function automatic lc3b_tag addr_tag(input lc3b_word addr);
        return addr[WORD_W-1:OFFSET_W];
    endfunction

endpackage

// File: rtl/word_select.sv
// 8:1 16-bit word mux selecting instruction word sel out of a 128-bit line.
module word_select
    import lc3b_types::*;
(
    input  lc3b_line               line,
    input  logic [SEL_W-1:0]       sel,
    output lc3b_word               word
);

    assign word = line[{sel, 4'b0000} +: WORD_W];

endmodule

// File: rtl/ifetch_line_buffer.sv
// Single-line instruction fetch buffer: same-cycle hits, one line fill per miss.
module ifetch_line_buffer
    import lc3b_types::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     if_read,
    input  lc3b_word if_address,
    output lc3b_word if_rdata,
    output logic     if_resp,
    input  logic     invalidate,
    output logic     pmem_read,
    output lc3b_word pmem_address,
    input  lc3b_line pmem_rdata,
    input  logic     pmem_resp,
    output logic [15:0] miss_count
);

    typedef enum logic {IDLE, FILL} state_t;

    state_t      state, state_next;
    lc3b_line    line_q;
    lc3b_tag     tag_q;
    lc3b_tag     fill_tag_q;
    logic        valid_q;
    logic        inval_pend_q;
    logic [15:0] miss_count_q;
    logic        hit;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = if_address[0];
    assign hit             = valid_q && (tag_q == addr_tag(if_address));
    assign miss_count      = miss_count_q;

    word_select u_word_select (
        .line (line_q),
        .sel  (if_address[3:1]),
        .word (if_rdata)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (if_read && !hit) state_next = FILL;
            FILL: if (pmem_resp)       state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Outputs; a hit is never reported while an invalidate is in flight
    always_comb begin
        if_resp      = 1'b0;
        pmem_read    = 1'b0;
        pmem_address = 16'h0000;
        case (state)
            IDLE: if_resp = if_read && hit && !invalidate;
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = {fill_tag_q, 4'b0000};
            end
            default: ;
        endcase
    end

    // Line storage, tag/valid and miss counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            line_q       <= '0;
            tag_q        <= '0;
            fill_tag_q   <= '0;
            valid_q      <= 1'b0;
            inval_pend_q <= 1'b0;
            miss_count_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    inval_pend_q <= 1'b0;
                    if (invalidate) valid_q <= 1'b0;
                    if (if_read && !hit) fill_tag_q <= addr_tag(if_address);
                end
                FILL: begin
                    if (invalidate) begin
                        valid_q      <= 1'b0;
                        inval_pend_q <= 1'b1;
                    end
                    if (pmem_resp) begin
                        line_q       <= pmem_rdata;
                        tag_q        <= fill_tag_q;
                        valid_q      <= !(inval_pend_q || invalidate);
                        inval_pend_q <= 1'b0;
                        if (miss_count_q != 16'hFFFF)
                            miss_count_q <= miss_count_q + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Directed bench for ifetch_line_buffer: cold miss, hits, invalidate, reset abort, saturation.
module tb_ifetch_line_buffer;
    import lc3b_types::*;

    logic        clk;
    logic        reset;
    logic        if_read;
    lc3b_word    if_address;
    lc3b_word    if_rdata;
    logic        if_resp;
    logic        invalidate;
    logic        pmem_read;
    lc3b_word    pmem_address;
    lc3b_line    pmem_rdata;
    logic        pmem_resp;
    logic [15:0] miss_count;

    int errors = 0;
    int checks = 0;

    lc3b_line line_a, line_b, line_c;

    ifetch_line_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .if_read      (if_read),
        .if_address   (if_address),
        .if_rdata     (if_rdata),
        .if_resp      (if_resp),
        .invalidate   (invalidate),
        .pmem_read    (pmem_read),
        .pmem_address (pmem_address),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .miss_count   (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            line_a[16*i +: 16] = 16'h1231 + 16'(i);
            line_b[16*i +: 16] = 16'hA0A0 + 16'(i);
            line_c[16*i +: 16] = 16'h5550 + 16'(i);
        end

        reset = 1'b1; if_read = 1'b0; if_address = 16'h0000; invalidate = 1'b0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        cyc(); #1;
        chk("rst_if_resp",   16'(if_resp),   16'h0000);
        chk("rst_pmem_read", 16'(pmem_read), 16'h0000);
        chk("rst_pmem_addr", pmem_address,   16'h0000);
        chk("rst_rdata",     if_rdata,       16'h0000);
        chk("rst_miss",      miss_count,     16'h0000);
        reset = 1'b0;

        // Cold miss at 0x3006 with a three-cycle memory
        cyc();
        if_read = 1'b1; if_address = 16'h3006; #1;
        chk("cold_idle_resp", 16'(if_resp), 16'h0000);
        chk("cold_idle_pread", 16'(pmem_read), 16'h0000);
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 2) begin pmem_resp = 1'b1; pmem_rdata = line_a; end
            #1;
            chk("cold_fill_pread", 16'(pmem_read), 16'h0001);
            chk("cold_fill_paddr", pmem_address,   16'h3000);
            chk("cold_fill_resp",  16'(if_resp),   16'h0000);
        end
        cyc();
        pmem_resp = 1'b0; #1;
        chk("cold_resp",  16'(if_resp),   16'h0001);
        chk("cold_rdata", if_rdata,       16'h1234);
        chk("cold_miss",  miss_count,     16'h0001);
        chk("cold_pread", 16'(pmem_read), 16'h0000);

        // Hit sweep across all eight words
        for (int i = 0; i < 8; i++) begin
            cyc();
            if_address = 16'h3000 + 16'(2 * i); #1;
            chk("hit_resp",  16'(if_resp),   16'h0001);
            chk("hit_rdata", if_rdata,       16'h1231 + 16'(i));
            chk("hit_pread", 16'(pmem_read), 16'h0000);
        end
        cyc();
        if_address = 16'h3007; #1;
        chk("hit_odd_rdata", if_rdata, 16'h1234);

        // Invalidate then re-read 0x3002
        cyc();
        invalidate = 1'b1; if_address = 16'h3002; #1;
        chk("inval_resp", 16'(if_resp), 16'h0000);
        cyc();
        invalidate = 1'b0; #1;
        chk("inval_after_resp", 16'(if_resp), 16'h0000);
        cyc();
        pmem_resp = 1'b1; pmem_rdata = line_b; #1;
        chk("inval_fill_paddr", pmem_address, 16'h3000);
        cyc();
        pmem_resp = 1'b0; #1;
        chk("inval_refill_rdata", if_rdata,   16'hA0A1);
        chk("inval_refill_miss",  miss_count, 16'h0002);

        // Reset in the middle of a fill; later pmem_resp must be ignored
        cyc();
        if_address = 16'h5000;
        cyc(); #1;
        chk("rstfill_pread", 16'(pmem_read), 16'h0001);
        reset = 1'b1; if_read = 1'b0; #1;
        chk("rstfill_pread0", 16'(pmem_read), 16'h0000);
        chk("rstfill_miss0",  miss_count,     16'h0000);
        chk("rstfill_rdata0", if_rdata,       16'h0000);
        cyc();
        reset = 1'b0;
        cyc();
        pmem_resp = 1'b1; pmem_rdata = line_c;
        cyc();
        pmem_resp = 1'b0; if_read = 1'b1; if_address = 16'h5000; #1;
        chk("late_resp_nohit",  16'(if_resp), 16'h0000);
        chk("late_resp_rdata",  if_rdata,     16'h0000);
        chk("late_resp_miss",   miss_count,   16'h0000);
        cyc();
        pmem_resp = 1'b1; pmem_rdata = line_c;
        cyc();
        pmem_resp = 1'b0; #1;
        chk("rstfill_hit_rdata", if_rdata,   16'h5550);
        chk("rstfill_miss1",     miss_count, 16'h0001);

        // Address changes while the fill to 0x3000 is outstanding
        cyc();
        if_address = 16'h3000;
        cyc();
        if_address = 16'h4000; #1;
        chk("chg_paddr0", pmem_address, 16'h3000);
        cyc();
        pmem_resp = 1'b1; pmem_rdata = line_a; #1;
        chk("chg_paddr1", pmem_address, 16'h3000);
        cyc();
        pmem_resp = 1'b0; #1;
        chk("chg_idle_resp", 16'(if_resp), 16'h0000);
        chk("chg_miss2",     miss_count,   16'h0002);
        cyc();
        pmem_resp = 1'b1; pmem_rdata = line_b; #1;
        chk("chg_paddr2", pmem_address, 16'h4000);
        cyc();
        pmem_resp = 1'b0; #1;
        chk("chg_hit_resp",  16'(if_resp), 16'h0001);
        chk("chg_hit_rdata", if_rdata,     16'hA0A0);
        chk("chg_miss3",     miss_count,   16'h0003);

        // Invalidate coinciding with pmem_resp leaves the line invalid
        if_address = 16'h3000;
        cyc();
        invalidate = 1'b1; pmem_resp = 1'b1; pmem_rdata = line_a; #1;
        chk("invfill_pread", 16'(pmem_read), 16'h0001);
        cyc();
        invalidate = 1'b0; pmem_resp = 1'b0; #1;
        chk("invfill_nohit", 16'(if_resp), 16'h0000);
        chk("invfill_miss4", miss_count,   16'h0004);
        cyc(); #1;
        chk("invfill_refetch", 16'(pmem_read), 16'h0001);
        if_read = 1'b0; pmem_resp = 1'b1;
        cyc();
        pmem_resp = 1'b0; if_read = 1'b1; #1;
        chk("noread_fill_resp",  16'(if_resp), 16'h0001);
        chk("noread_fill_rdata", if_rdata,     16'h1231);
        if_read = 1'b0;

        // Saturation: preload the counter near its limit, then fill twice
        cyc();
        force dut.miss_count_q = 16'hFFFE;
        #1;
        release dut.miss_count_q;
        #1;
        chk("sat_preload", miss_count, 16'hFFFE);
        for (int i = 0; i < 2; i++) begin
            cyc();
            if_read = 1'b1; if_address = (i == 0) ? 16'h6000 : 16'h7000;
            cyc();
            pmem_resp = 1'b1; pmem_rdata = line_c;
            cyc();
            pmem_resp = 1'b0; #1;
            chk("sat_count", miss_count, 16'hFFFF);
            chk("sat_resp",  16'(if_resp), 16'h0001);
        end
        if_read = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifetch_line_buffer.md
IFETCH_LINE_BUFFER -- requirements
Module: ifetch_line_buffer

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port if_read, input, 1, fetch request from the fetch stage.
REQ-004 SHALL have port if_address, input, lc3b_word, fetch address (PC).
REQ-005 SHALL have port if_rdata, output, lc3b_word, instruction word returned.
REQ-006 SHALL have port if_resp, output, 1, fetch-complete strobe.
REQ-007 SHALL have port invalidate, input, 1, clear buffered line (flush/self-modifying code).
REQ-008 SHALL have port pmem_read, output, 1, line read request to physical memory.
REQ-009 SHALL have port pmem_address, output, lc3b_word, line-aligned read address.
REQ-010 SHALL have port pmem_rdata, input, lc3b_line (128 bits), returned line.
REQ-011 SHALL have port pmem_resp, input, 1, physical read complete.
REQ-012 SHALL have port miss_count, output, 16, saturating count of line fills.

Function
REQ-013 SHALL hold one 128-bit line, a 12-bit tag (address[15:4]) and a valid bit.
REQ-014 SHALL define hit as valid && tag == if_address[15:4]; if_address[0] is ignored.
REQ-015 SHALL have FSM states IDLE and FILL.
REQ-016 SHALL, in IDLE with if_read && hit, assert if_resp combinationally in the same cycle; if_rdata = line word if_address[3:1], where word i = bits [16i+15:16i].
REQ-017 SHALL, in IDLE with if_read && !hit, latch fill_tag = if_address[15:4] and go to FILL next edge; if_resp stays 0.
REQ-018 SHALL, in FILL, hold pmem_read = 1 and pmem_address = {fill_tag, 4'b0000} every cycle until pmem_resp.
REQ-019 SHALL, on pmem_resp in FILL, write pmem_rdata to the line, fill_tag to the tag, set valid, increment miss_count (saturating at 16'hFFFF), and return to IDLE.
REQ-020 SHALL deliver miss latency as: if_resp asserted the cycle after pmem_resp, provided if_read is held and the address is unchanged.
REQ-021 SHALL complete an in-progress fill even if if_read deasserts or if_address changes; the hit check is re-evaluated in IDLE.
REQ-022 SHALL clear valid on invalidate in IDLE; if_resp SHALL be 0 in any cycle where invalidate = 1.
REQ-023 SHALL, on invalidate in FILL, complete the fill with valid left 0; if invalidate coincides with pmem_resp, valid SHALL be 0.
REQ-024 SHALL drive pmem_read = 0 in IDLE and if_resp = 0 in FILL.
REQ-025 SHALL drive pmem_address = 16'h0000 in IDLE.

Reset
REQ-026 SHALL, on reset asserted at any time (including mid-FILL), immediately enter IDLE with valid = 0, tag = 0, fill_tag = 0, line = 0, miss_count = 0; if_resp = 0, pmem_read = 0, if_rdata = 16'h0000.
REQ-027 SHALL, after reset, ignore a pmem_resp belonging to an aborted fill (no line write).

Structure
REQ-028 SHALL take lc3b_word and lc3b_line from lc3b_types; the state enum SHALL be local to the module.
REQ-029 SHALL instantiate one sub-module, word_select (8:1 16-bit mux indexed by address[3:1]).

Verification
REQ-030 Cold miss: reset, if_read = 1, if_address = 16'h3006, pmem_rdata word3 = 16'h1234 after 3 cycles -> pmem_address = 16'h3000 held, if_resp the cycle after pmem_resp, if_rdata = 16'h1234, miss_count = 1.
REQ-031 Hit sequence: after REQ-030, addresses 16'h3000..16'h300E -> if_resp every cycle, words 0..7 returned, no pmem_read.
REQ-032 Invalidate: after fill, invalidate = 1 one cycle, then read 16'h3002 -> new fill to 16'h3000, miss_count = 2.
REQ-033 Reset mid-fill: reset during FILL before pmem_resp -> IDLE, pmem_read = 0, valid = 0; late pmem_resp has no effect.
REQ-034 Address change mid-fill: miss at 16'h3000, switch to 16'h4000 before pmem_resp -> fill to 16'h3000 completes, then a second fill to 16'h4000.
REQ-035 Saturation: force 65536 fills -> miss_count holds at 16'hFFFF.
